// File: rtl/axil_stage_regs_if.sv
// AXI4-Lite bus bundle for the stage register block.
// The master drives requests and the slave drives readys and responses.
interface axil_stage_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_stage_regs.sv
// AXI4-Lite control/status registers for the packet stages.
// Provides the stage enable, a counter clear, and the packet/error counters.
module axil_stage_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h4D4E5331
) (
  input  logic             axil_aclk,
  input  logic             axil_aresetn,
  axil_stage_regs_if.slave s_axil,
  input  logic             pkt_done,
  input  logic             pkt_err,
  output logic             stage_enable
);

  localparam int unsigned WA = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    SEL_ID, SEL_SCRATCH, SEL_CTRL, SEL_PKT, SEL_ERR, SEL_NONE
  } sel_e;

  // Word address in, register select out; any high bit set is a miss.
  function automatic sel_e decode(input logic [WA-1:0] wa);
    sel_e sel;
    sel = SEL_NONE;
    if (wa[WA-1:11] == '0) begin
      case (wa[10:0])
        11'h000: sel = SEL_ID;
        11'h001: sel = SEL_SCRATCH;
        11'h400: sel = SEL_CTRL;
        11'h401: sel = SEL_PKT;
        11'h402: sel = SEL_ERR;
        default: sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [1:0] wr_resp(input sel_e sel);
    logic [1:0] resp;
    case (sel)
      SEL_SCRATCH, SEL_CTRL: resp = 2'b00;
      SEL_NONE:              resp = 2'b11;
      default:               resp = 2'b10;
    endcase
    return resp;
  endfunction

  logic          ready_en_q;
  logic          aw_held_q, aw_held_d;
  logic [WA-1:0] aw_addr_q, aw_addr_d;
  logic          w_held_q, w_held_d;
  logic [31:0]   w_data_q, w_data_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   scratch_q, scratch_d;
  logic          ctrl_q, ctrl_d;
  logic          clear_cnt;
  logic          commit;
  logic          aw_hs, w_hs, ar_hs;
  logic [1:0]    pulse;
  logic [31:0]   pkt_count, err_count;
  logic          unused_addr_lsbs;

  // Readys stay low in reset and rise on the first edge after release.
  assign s_axil.awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign s_axil.wready  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign s_axil.arready = ready_en_q & ~rvalid_q;

  assign aw_hs  = s_axil.awvalid & s_axil.awready;
  assign w_hs   = s_axil.wvalid & s_axil.wready;
  assign ar_hs  = s_axil.arvalid & s_axil.arready;
  assign commit = aw_held_q & w_held_q;

  assign unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    clear_cnt = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      case (decode(aw_addr_q))
        SEL_SCRATCH: scratch_d = w_data_q;
        SEL_CTRL: begin
          ctrl_d    = w_data_q[0];
          clear_cnt = w_data_q[1];
        end
        default: ;
      endcase
    end
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axil.awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axil.wdata;
    end
    if (bvalid_q && s_axil.bready) begin
      bvalid_d = 1'b0;
    end
    // The response is raised as soon as the pair completes, ahead of the commit edge.
    if ((aw_hs || w_hs) && aw_held_d && w_held_d) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_resp(decode(aw_addr_d));
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil.rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = 2'b00;
      case (decode(s_axil.araddr[ADDR_WIDTH-1:2]))
        SEL_ID:      rdata_d = ID_VALUE;
        SEL_SCRATCH: rdata_d = scratch_q;
        SEL_CTRL:    rdata_d = {31'b0, ctrl_q};
        SEL_PKT:     rdata_d = pkt_count;
        SEL_ERR:     rdata_d = err_count;
        default: begin
          rdata_d = '0;
          rresp_d = 2'b11;
        end
      endcase
    end
  end

  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      scratch_q  <= '0;
      ctrl_q     <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
    end
  end

  // Clear takes priority over a coincident pulse.
  assign pulse = {pkt_err, pkt_done};
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (clear_cnt) begin
        cnt_d = '0;
      end else if (pulse[gi]) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
    always_ff @(posedge axil_aclk) begin
      if (!axil_aresetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign pkt_count = g_cnt[0].cnt_q;
  assign err_count = g_cnt[1].cnt_q;

  assign s_axil.bvalid = bvalid_q;
  assign s_axil.bresp  = bresp_q;
  assign s_axil.rvalid = rvalid_q;
  assign s_axil.rdata  = rdata_q;
  assign s_axil.rresp  = rresp_q;
  assign stage_enable  = ctrl_q;

endmodule

// File: tb/tb_axil_stage_regs.sv
// Directed plus randomized bench for axil_stage_regs against a register-map model.
module tb_axil_stage_regs;
  localparam logic [31:0] ID = 32'h4D4E5331;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic pkt_done = 1'b0;
  logic pkt_err = 1'b0;
  logic stage_enable;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  axil_stage_regs_if #(.ADDR_WIDTH(32)) bus ();

  axil_stage_regs #(.ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
    .axil_aclk    (clk),
    .axil_aresetn (aresetn),
    .s_axil       (bus),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err),
    .stage_enable (stage_enable)
  );

  // Register-map model
  logic [31:0] m_scratch = 0;
  logic        m_en = 0;
  logic [31:0] m_pkt = 0;
  logic [31:0] m_err = 0;

  task automatic m_reset();
    m_scratch = 0; m_en = 0; m_pkt = 0; m_err = 0;
  endtask

  function automatic logic [33:0] m_read(input logic [31:0] a);
    case (a & 32'hFFFF_FFFC)
      32'h0000: return {2'b00, ID};
      32'h0004: return {2'b00, m_scratch};
      32'h1000: return {2'b00, 31'b0, m_en};
      32'h1004: return {2'b00, m_pkt};
      32'h1008: return {2'b00, m_err};
      default:  return {2'b11, 32'h0};
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    case (a & 32'hFFFF_FFFC)
      32'h0004: begin m_scratch = d; resp = 2'b00; end
      32'h1000: begin
        m_en = d[0];
        if (d[1]) begin m_pkt = 0; m_err = 0; end
        resp = 2'b00;
      end
      32'h0000, 32'h1004, 32'h1008: resp = 2'b10;
      default: resp = 2'b11;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input bit pulse_commit, input string tag);
    logic [1:0] exp_resp;
    int t;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    t = 0;
    while (!(bus.awready && bus.wready) && t < 20) begin @(negedge clk); t++; end
    check({tag, "_awwready"}, 32'(bus.awready & bus.wready), 32'd1);
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 0;
    if (pulse_commit) begin pkt_done = 1; m_pkt++; end
    m_write(a, d, exp_resp);
    check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
    @(negedge clk);
    pkt_done = 0; bus.bready = 0;
    check({tag, "_bdone"}, 32'(bus.bvalid), 32'd0);
    check({tag, "_en"}, 32'(stage_enable), 32'(m_en));
    $display("WR  %s addr=%h data=%h bresp=%b", tag, a, d, bus.bresp);
  endtask

  task automatic axi_read(input logic [31:0] a, input bit pulse_ar, input string tag);
    logic [33:0] exp;
    int t;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge clk); t++; end
    check({tag, "_arready"}, 32'(bus.arready), 32'd1);
    exp = m_read(a);
    if (pulse_ar) begin pkt_done = 1; m_pkt++; end
    @(negedge clk);
    bus.arvalid = 0; pkt_done = 0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp[31:0]);
    check({tag, "_rresp"}, 32'(bus.rresp), 32'(exp[33:32]));
    $display("RD  %s addr=%h rdata=%h rresp=%b", tag, a, bus.rdata, bus.rresp);
    @(negedge clk);
    bus.rready = 0;
    check({tag, "_rdone"}, 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] addrs [10];
    logic [31:0] a;
    logic [1:0]  r;
    int unsigned op;

    addrs = '{32'h0, 32'h4, 32'h1000, 32'h1004, 32'h1008,
              32'h10, 32'h100C, 32'h2000, 32'h8000_1000, 32'h0FF0};
    bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_en", 32'(stage_enable), 32'd0);
    aresetn = 1;
    @(negedge clk);
    check("rel_awready", 32'(bus.awready), 32'd1);
    check("rel_arready", 32'(bus.arready), 32'd1);

    axi_read(32'h0, 0, "id");
    axi_write(32'h1000, 32'h1, 0, "ctrl_en");
    axi_read(32'h1000, 0, "ctrl_rd");

    // W leads AW by 3 cycles, B held off for 5 cycles
    @(negedge clk);
    bus.wdata = 32'hA5A5_A5A5; bus.wvalid = 1; bus.bready = 0;
    check("wf_wready", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 0;
    check("wf_wheld", 32'(bus.wready), 32'd0);
    check("wf_awready", 32'(bus.awready), 32'd1);
    check("wf_nob", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 32'h4; bus.awvalid = 1;
    check("wf_aw_ok", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 0;
    m_write(32'h4, 32'hA5A5_A5A5, r);
    check("wf_bresp", 32'(bus.bresp), 32'(r));
    for (int k = 0; k < 5; k++) begin
      check("wf_hold_b", 32'(bus.bvalid), 32'd1);
      check("wf_hold_rdy", 32'({bus.awready, bus.wready}), 32'd0);
      @(negedge clk);
    end
    bus.bready = 1;
    @(negedge clk);
    bus.bready = 0;
    check("wf_bdone", 32'(bus.bvalid), 32'd0);
    check("wf_rdy_back", 32'({bus.awready, bus.wready}), 32'd3);
    $display("WR  wfirst addr=00000004 data=a5a5a5a5 bresp=%b", r);
    axi_read(32'h4, 0, "scratch");

    // Counters, then clear colliding with a pulse
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pkt_done = 1; m_pkt++;
      if (k < 2) begin pkt_err = 1; m_err++; end
      @(negedge clk);
      pkt_done = 0; pkt_err = 0;
    end
    axi_read(32'h1004, 0, "pkt5");
    axi_read(32'h1008, 0, "err2");
    axi_read(32'h1004, 1, "pkt_pre_inc");
    axi_write(32'h1000, 32'h3, 1, "clear");
    axi_read(32'h1004, 0, "pkt_clr");
    axi_read(32'h1008, 0, "err_clr");
    axi_read(32'h1000, 0, "ctrl_after_clr");

    // Error responses
    axi_write(32'h1004, 32'hFFFF_FFFF, 0, "ro_pkt");
    axi_read(32'h1004, 0, "pkt_unch");
    axi_write(32'h0, 32'h1234, 0, "ro_id");
    axi_write(32'h2000, 32'h5555, 0, "unmapped_wr");
    axi_read(32'h0FF0, 0, "unmapped_rd");

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      a = addrs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
      case (op)
        0: axi_write(a, $urandom, 0, "rnd_wr");
        1: axi_read(a, 0, "rnd_rd");
        2: begin
          @(negedge clk);
          pkt_done = 1'($urandom_range(0, 1));
          pkt_err  = 1'($urandom_range(0, 1));
          m_pkt = m_pkt + 32'(pkt_done);
          m_err = m_err + 32'(pkt_err);
          @(negedge clk);
          pkt_done = 0; pkt_err = 0;
        end
        default: axi_read(a, 1, "rnd_rd_pulse");
      endcase
    end

    // Reset with AW held and W pending
    axi_write(32'h4, 32'hDEAD_BEEF, 0, "pre_rst");
    @(negedge clk);
    bus.awaddr = 32'h4; bus.wdata = 32'h0BAD_0BAD; bus.awvalid = 1; bus.bready = 1;
    @(negedge clk);
    bus.awvalid = 0;
    check("mid_aw_held", 32'({bus.awready, bus.wready}), 32'd1);
    aresetn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_no_b", 32'(bus.bvalid), 32'd0);
    end
    aresetn = 1;
    m_reset();
    @(negedge clk);
    check("mid_no_b_rel", 32'(bus.bvalid), 32'd0);
    bus.bready = 0;
    axi_read(32'h4, 0, "rst_scratch");
    axi_read(32'h1000, 0, "rst_ctrl");
    axi_read(32'h1004, 0, "rst_pkt");
    axi_read(32'h1008, 0, "rst_err");
    axi_write(32'h4, 32'h1234_5678, 0, "post_rst");
    axi_read(32'h4, 0, "post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_stage_regs.md
# axil_stage_regs

AXI4-Lite slave register block that answers the host's control-plane accesses to the user-logic stages. It sits behind the shell's `s_axil` port, on the user-box side. It exposes a stage enable and a counter clear to the packet pipeline, and reports packet and error counts back to the host. It is the responder for the AW/W/B and AR/R transactions that the host and the bench issue, including the `0x00001000 <= 0x00000001` stage-enable write.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI-Lite address width. Bits [1:0] are ignored and bits [ADDR_WIDTH-1:13] must be zero for a hit.
- `ID_VALUE`, 32'h4D4E5331: constant returned by the ID register.

Ports:
- `axil_aclk` in 1: the single clock.
- `axil_aresetn` in 1: reset, synchronous, active-low.
- `s_axil_awvalid` / `s_axil_awready` in/out 1: write address handshake.
- `s_axil_awaddr` in ADDR_WIDTH: write address.
- `s_axil_wvalid` / `s_axil_wready` in/out 1: write data handshake.
- `s_axil_wdata` in 32: write data. Writes are full-word; there is no strobe.
- `s_axil_bvalid` out 1 / `s_axil_bready` in 1: write response handshake.
- `s_axil_bresp` out 2: write response code.
- `s_axil_arvalid` / `s_axil_arready` in/out 1: read address handshake.
- `s_axil_araddr` in ADDR_WIDTH: read address.
- `s_axil_rvalid` out 1 / `s_axil_rready` in 1: read data handshake.
- `s_axil_rdata` out 32: read data.
- `s_axil_rresp` out 2: read response code.
- `pkt_done` in 1: one-cycle pulse per packet completed by the stages.
- `pkt_err` in 1: one-cycle pulse per packet dropped or errored.
- `stage_enable` out 1: CTRL[0].

## Operation
Register map (offsets):
- 0x0000 ID, RO: `ID_VALUE`.
- 0x0004 SCRATCH, RW.
- 0x1000 CTRL, RW.
  - bit0 is `stage_enable`.
  - bit1 is CLEAR: it is write-only and self-clearing, and always reads 0.
  - bits [31:2] read 0.
- 0x1004 PKT_COUNT, RO: 32-bit count of `pkt_done` pulses, wraps at 2^32.
- 0x1008 ERR_COUNT, RO: 32-bit count of `pkt_err` pulses, wraps at 2^32.

Write path:
- AW and W are captured independently into holding registers, in either order or in the same cycle.
  - `awready` = no AW held and no B pending.
  - `wready` = no W held and no B pending.
- When both AW and W are held, the write commits in the next cycle, both holds clear, and `bvalid` rises.
- `bvalid` stays high until `bready`. While `bvalid` is high, no new AW or W is accepted.
- `bresp` values:
  - OKAY (00) for SCRATCH and CTRL.
  - SLVERR (10) for ID, PKT_COUNT and ERR_COUNT. The register is unchanged.
  - DECERR (11) for an unmapped address. No state changes.

Read path:
- `arready` = not `rvalid`.
- On the AR handshake, the addressed register is sampled into `rdata` and `rvalid` rises in the next cycle.
- `rdata` and `rresp` stay stable until `rready`.
- `rresp` values:
  - OKAY for mapped addresses.
  - DECERR for unmapped addresses, with `rdata` = 0.

Counters:
- A CLEAR write zeroes both counters in its commit cycle.
- If CLEAR coincides with a pulse, clear wins and the count is 0.
- If a counter is read in the same cycle it increments, the pre-increment value is returned.

Reads and writes are independent channels. A read and a write commit in the same cycle are both serviced.

## Timing
Reset (`axil_aresetn` = 0 at a clock edge):
- `awready`, `wready`, `arready`, `bvalid` and `rvalid` are 0.
- `bresp`, `rresp`, `rdata`, SCRATCH, CTRL, both counters and `stage_enable` are 0.
- The readys become 1 on the first edge after reset is released.

Latency:
- Write, AW and W together in cycle N: the register and `stage_enable` update at the end of cycle N+1, and `bvalid` is high in cycle N+1.
- Read, AR in cycle N: `rvalid` is high in cycle N+1.

Throughput:
- One write per 2 cycles when `bready` is held high.
- One read per 2 cycles.

Reset mid-transaction: all pending AW, W, B and R state is discarded. No response is issued for the interrupted transaction.

## Test plan
- After reset, read 0x0000: `rdata` = 4D4E5331, `rresp` = 00, `rvalid` one cycle after `arready`.
- Write 0x00001000 = 00000001 with AW and W in the same cycle, `bready` = 1:
  - `bvalid` next cycle with `bresp` = 00;
  - `stage_enable` = 1;
  - reading 0x1000 returns 00000001.
- Write 0x0004 = A5A5A5A5 with W presented 3 cycles before AW, and `bready` held low for 5 cycles:
  - `awready` and `wready` stay 0 while `bvalid` is held;
  - a later read of 0x0004 returns A5A5A5A5.
- Pulse `pkt_done` 5 times and `pkt_err` 2 times:
  - PKT_COUNT = 5 and ERR_COUNT = 2;
  - write 0x1000 = 00000003 in the same cycle as one more `pkt_done`;
  - both counters read 0, and `stage_enable` = 1.
- Write 0x1004 = FFFFFFFF: `bresp` = 10 and PKT_COUNT is unchanged. Write 0x2000: `bresp` = 11. Read 0x0FF0: `rresp` = 11, `rdata` = 0.
- Assert reset while AW is held and W is still pending: no `bvalid` appears, all registers read 0 afterward, and the next write completes normally.
